// File: rtl/loader_pkg.sv
// Shared types and RV32I encoding constants for the instruction loader and its encoder.
package loader_pkg;

  typedef enum logic [4:0] {
    K_LW   = 5'd0,  K_SW   = 5'd1,  K_ADD  = 5'd2,  K_SUB  = 5'd3,
    K_SLT  = 5'd4,  K_XOR  = 5'd5,  K_OR   = 5'd6,  K_AND  = 5'd7,
    K_ADDI = 5'd8,  K_SLTI = 5'd9,  K_XORI = 5'd10, K_ORI  = 5'd11,
    K_ANDI = 5'd12, K_BEQ  = 5'd13, K_JAL  = 5'd14, K_JALR = 5'd15
  } cmd_kind_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Register and immediate ALU forms share funct3.
  function automatic logic [2:0] alu_f3(input logic [4:0] kind);
    case (kind)
      K_SLT, K_SLTI: return F3_SLT;
      K_XOR, K_XORI: return F3_XOR;
      K_OR,  K_ORI:  return F3_OR;
      K_AND, K_ANDI: return F3_AND;
      default:       return F3_ADD;
    endcase
  endfunction

endpackage

// File: rtl/imem_program_loader_encoder.sv
// rv32_instr_encoder: combinational symbolic-command to RV32I word encoder with immediate range check.
module rv32_instr_encoder
  import loader_pkg::*;
(
  input  logic [4:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_err
);

  logic fit_is, fit_b, fit_j;

  assign fit_is = in_range(imm, -2048, 2047);
  assign fit_b  = in_range(imm, -4096, 4094) && !imm[0];
  assign fit_j  = in_range(imm, -1048576, 1048574) && !imm[0];

  always_comb begin
    word      = NOP_INSN;
    range_err = 1'b0;
    case (kind)
      K_ADD, K_SUB, K_SLT, K_XOR, K_OR, K_AND:
        word = {(kind == K_SUB) ? F7_SUB : F7_BASE, rs2, rs1, alu_f3(kind), rd, OP_R};
      K_ADDI, K_SLTI, K_XORI, K_ORI, K_ANDI: begin
        word      = {imm[11:0], rs1, alu_f3(kind), rd, OP_I};
        range_err = !fit_is;
      end
      K_LW: begin
        word      = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
        range_err = !fit_is;
      end
      K_JALR: begin
        word      = {imm[11:0], rs1, F3_JALR, rd, OP_JALR};
        range_err = !fit_is;
      end
      K_SW: begin
        word      = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
        range_err = !fit_is;
      end
      K_BEQ: begin
        word      = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
        range_err = !fit_b;
      end
      K_JAL: begin
        word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        range_err = !fit_j;
      end
      default: range_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// Boot loader: encodes command stream into IMEM from address 0, holds CPU in reset until done.
// Optional running checksum of written words enabled by PROG_CHECKSUM_EN.
module imem_program_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_kind,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [31:0]       cmd_imm,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_imm,
  output logic              err_full,
  output logic [31:0]       checksum
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [31:0]       enc_word;
  logic              enc_err;
  logic              accept;
  logic              at_end;

  assign accept = cmd_valid && cmd_ready;
  assign at_end = (cnt == ADDR_W'(DEPTH - 1));

  rv32_instr_encoder u_enc (
    .kind      (cmd_kind),
    .rd        (cmd_rd),
    .rs1       (cmd_rs1),
    .rs2       (cmd_rs2),
    .imm       (cmd_imm),
    .word      (enc_word),
    .range_err (enc_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err_imm    <= 1'b0;
      err_full   <= 1'b0;
      cnt        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= accept;
      if (accept) begin
        imem_addr  <= cnt;
        imem_wdata <= enc_err ? NOP_INSN : enc_word;
        err_imm    <= err_imm | enc_err;
        cnt        <= cnt + 1'b1;
      end
      case (state)
        S_LOAD: begin
          // The accepted word is still written even when it fills the last slot.
          if (accept && cmd_last) begin
            state     <= S_DONE;
            cmd_ready <= 1'b0;
            done      <= 1'b1;
            cpu_hold  <= 1'b0;
          end else if (accept && at_end) begin
            state     <= S_ERR;
            cmd_ready <= 1'b0;
            err_full  <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state     <= S_LOAD;
            cmd_ready <= 1'b1;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err_imm   <= 1'b0;
            err_full  <= 1'b0;
            cnt       <= '0;
          end
        end
      endcase
    end
  end

`ifdef PROG_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      checksum <= '0;
    else if (start && state != S_LOAD)
      checksum <= '0;
    else if (imem_we)
      checksum <= checksum + imem_wdata;
  end
`else
  assign checksum = '0;
`endif

endmodule
